// File: rtl/arithmetic_execute_unit_pkg.sv
// Shared types for the integer execute unit: operand width, ALU opcodes,
// AArch64 condition codes and the NZCV flag record.
package arithmetic_execute_unit_pkg;

  localparam int GPR_SIZE = 64;

  typedef enum logic [4:0] {
    ALU_PLUS   = 5'd0,
    ALU_MINUS  = 5'd1,
    ALU_ORN    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_EOR    = 5'd4,
    ALU_AND    = 5'd5,
    ALU_MOVK   = 5'd6,
    ALU_LSL    = 5'd7,
    ALU_LSR    = 5'd8,
    ALU_ASR    = 5'd9,
    ALU_PASS_A = 5'd10,
    ALU_CSEL   = 5'd11,
    ALU_CSINV  = 5'd12,
    ALU_CSINC  = 5'd13,
    ALU_CSNEG  = 5'd14,
    ALU_CBZ    = 5'd15,
    ALU_CBNZ   = 5'd16
  } alu_op_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

// File: rtl/arithmetic_execute_unit_cond_eval.sv
// Combinational AArch64 condition-code evaluator over a supplied NZCV value.
module arithmetic_execute_unit_cond_eval
  import arithmetic_execute_unit_pkg::*;
(
  input  cond_t in_cond,
  input  nzcv_t in_nzcv,
  output logic  out_taken
);

  logic ge_s;
  logic hi_s;

  assign ge_s = (in_nzcv.n == in_nzcv.v);
  assign hi_s = in_nzcv.c & ~in_nzcv.z;

  // Condition table; AL and NV both mean "always".
  always_comb begin
    out_taken = 1'b0;
    case (in_cond)
      COND_EQ: out_taken = in_nzcv.z;
      COND_NE: out_taken = ~in_nzcv.z;
      COND_CS: out_taken = in_nzcv.c;
      COND_CC: out_taken = ~in_nzcv.c;
      COND_MI: out_taken = in_nzcv.n;
      COND_PL: out_taken = ~in_nzcv.n;
      COND_VS: out_taken = in_nzcv.v;
      COND_VC: out_taken = ~in_nzcv.v;
      COND_HI: out_taken = hi_s;
      COND_LS: out_taken = ~hi_s;
      COND_GE: out_taken = ge_s;
      COND_LT: out_taken = ~ge_s;
      COND_GT: out_taken = ~in_nzcv.z & ge_s;
      COND_LE: out_taken = ~(~in_nzcv.z & ge_s);
      COND_AL: out_taken = 1'b1;
      COND_NV: out_taken = 1'b1;
      default: out_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/arithmetic_execute_unit.sv
// Single-cycle integer ALU functional unit: result, NZCV and condition bit are
// computed combinationally and registered once for the broadcast path.
module arithmetic_execute_unit
  import arithmetic_execute_unit_pkg::*;
(
  input  logic                in_clk,
  input  logic                in_rst,
  input  logic                in_valid,
  input  alu_op_t             in_alu_op,
  input  logic [GPR_SIZE-1:0] in_val_a,
  input  logic [GPR_SIZE-1:0] in_val_b,
  input  logic [5:0]          in_alu_val_hw,
  input  logic                in_set_CC,
  input  cond_t               in_cond,
  input  nzcv_t               in_prev_nzcv,
  output logic [GPR_SIZE-1:0] out_res,
  output nzcv_t               out_nzcv,
  output logic                out_cond_val,
  output logic                out_fu_done
);

  logic [GPR_SIZE-1:0] res_s;
  logic [GPR_SIZE:0]   sum_s;
  logic [GPR_SIZE:0]   diff_s;
  logic                carry_s;
  logic                ovf_s;
  logic                known_op_s;
  logic                cond_s;
  logic                cond_val_s;
  nzcv_t               nzcv_s;

  logic [GPR_SIZE-1:0] res_d,      res_q;
  nzcv_t               nzcv_d,     nzcv_q;
  logic                cond_val_d, cond_val_q;
  logic                fu_done_d,  fu_done_q;

  // Conditions always look at the incoming flags, never this cycle's result.
  arithmetic_execute_unit_cond_eval u_cond_eval (
    .in_cond   (in_cond),
    .in_nzcv   (in_prev_nzcv),
    .out_taken (cond_s)
  );

  // Datapath: result, flag generation and next-state selection.
  always_comb begin
    sum_s      = {1'b0, in_val_a} + {1'b0, in_val_b};
    diff_s     = {1'b0, in_val_a} + {1'b0, ~in_val_b} + 65'd1;
    res_s      = '0;
    carry_s    = 1'b0;
    ovf_s      = 1'b0;
    known_op_s = 1'b1;
    cond_val_s = cond_s;
    case (in_alu_op)
      ALU_PLUS: begin
        res_s   = sum_s[GPR_SIZE-1:0];
        carry_s = sum_s[GPR_SIZE];
        ovf_s   = (in_val_a[63] == in_val_b[63]) && (res_s[63] != in_val_a[63]);
      end
      ALU_MINUS: begin
        res_s   = diff_s[GPR_SIZE-1:0];
        carry_s = diff_s[GPR_SIZE];
        ovf_s   = (in_val_a[63] != in_val_b[63]) && (res_s[63] != in_val_a[63]);
      end
      ALU_ORN:    res_s = in_val_a | ~in_val_b;
      ALU_OR:     res_s = in_val_a | in_val_b;
      ALU_EOR:    res_s = in_val_a ^ in_val_b;
      ALU_AND:    res_s = in_val_a & in_val_b;
      ALU_MOVK:   res_s = (in_val_a & ~(64'hFFFF << in_alu_val_hw))
                        | ({48'd0, in_val_b[15:0]} << in_alu_val_hw);
      ALU_LSL:    res_s = in_val_a << in_val_b[5:0];
      ALU_LSR:    res_s = in_val_a >> in_val_b[5:0];
      ALU_ASR:    res_s = $signed(in_val_a) >>> in_val_b[5:0];
      ALU_PASS_A: res_s = in_val_a;
      ALU_CSEL:   res_s = cond_s ? in_val_a : in_val_b;
      ALU_CSINV:  res_s = cond_s ? in_val_a : ~in_val_b;
      ALU_CSINC:  res_s = cond_s ? in_val_a : in_val_b + 64'd1;
      ALU_CSNEG:  res_s = cond_s ? in_val_a : ~in_val_b + 64'd1;
      ALU_CBZ: begin
        res_s      = in_val_a;
        cond_val_s = (in_val_a == 64'd0);
      end
      ALU_CBNZ: begin
        res_s      = in_val_a;
        cond_val_s = (in_val_a != 64'd0);
      end
      default: begin
        res_s      = '0;
        known_op_s = 1'b0;
      end
    endcase

    // Undefined opcodes never disturb the architectural flags.
    if (in_set_CC && known_op_s) begin
      nzcv_s = '{n: res_s[63], z: (res_s == 64'd0), c: carry_s, v: ovf_s};
    end else begin
      nzcv_s = in_prev_nzcv;
    end

    fu_done_d = in_valid;
    if (in_valid) begin
      res_d      = res_s;
      nzcv_d     = nzcv_s;
      cond_val_d = cond_val_s;
    end else begin
      res_d      = res_q;
      nzcv_d     = nzcv_q;
      cond_val_d = cond_val_q;
    end
  end

  // Output register stage with synchronous reset.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      res_q      <= '0;
      nzcv_q     <= '0;
      cond_val_q <= 1'b0;
      fu_done_q  <= 1'b0;
    end else begin
      res_q      <= res_d;
      nzcv_q     <= nzcv_d;
      cond_val_q <= cond_val_d;
      fu_done_q  <= fu_done_d;
    end
  end

  assign out_res      = res_q;
  assign out_nzcv     = nzcv_q;
  assign out_cond_val = cond_val_q;
  assign out_fu_done  = fu_done_q;

endmodule

// File: tb/tb_arithmetic_execute_unit.sv
// Directed self-checking bench for arithmetic_execute_unit.
module tb_arithmetic_execute_unit;
  import arithmetic_execute_unit_pkg::*;

  logic                in_clk;
  logic                in_rst;
  logic                in_valid;
  alu_op_t             in_alu_op;
  logic [GPR_SIZE-1:0] in_val_a;
  logic [GPR_SIZE-1:0] in_val_b;
  logic [5:0]          in_alu_val_hw;
  logic                in_set_CC;
  cond_t               in_cond;
  nzcv_t               in_prev_nzcv;
  logic [GPR_SIZE-1:0] out_res;
  nzcv_t               out_nzcv;
  logic                out_cond_val;
  logic                out_fu_done;

  int n_cmp = 0;
  int n_err = 0;

  arithmetic_execute_unit dut (
    .in_clk        (in_clk),
    .in_rst        (in_rst),
    .in_valid      (in_valid),
    .in_alu_op     (in_alu_op),
    .in_val_a      (in_val_a),
    .in_val_b      (in_val_b),
    .in_alu_val_hw (in_alu_val_hw),
    .in_set_CC     (in_set_CC),
    .in_cond       (in_cond),
    .in_prev_nzcv  (in_prev_nzcv),
    .out_res       (out_res),
    .out_nzcv      (out_nzcv),
    .out_cond_val  (out_cond_val),
    .out_fu_done   (out_fu_done)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input alu_op_t op, input logic [63:0] a, input logic [63:0] b,
                       input logic [5:0] hw, input logic cc, input cond_t cond,
                       input logic [3:0] prev);
    in_valid      = 1'b1;
    in_alu_op     = op;
    in_val_a      = a;
    in_val_b      = b;
    in_alu_val_hw = hw;
    in_set_CC     = cc;
    in_cond       = cond;
    in_prev_nzcv  = nzcv_t'(prev);
    @(posedge in_clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge in_clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [63:0] res, input logic [3:0] nzcv,
                            input logic cv, input logic done);
    check({tag, ".res"},  out_res, res);
    check({tag, ".nzcv"}, {60'd0, out_nzcv}, {60'd0, nzcv});
    check({tag, ".cond"}, {63'd0, out_cond_val}, {63'd0, cv});
    check({tag, ".done"}, {63'd0, out_fu_done}, {63'd0, done});
  endtask

  initial begin
    in_rst = 1'b1;
    in_valid = 1'b0;
    in_alu_op = ALU_PLUS;
    in_val_a = 64'd0;
    in_val_b = 64'd0;
    in_alu_val_hw = 6'd0;
    in_set_CC = 1'b0;
    in_cond = COND_AL;
    in_prev_nzcv = nzcv_t'(4'b0000);
    @(posedge in_clk);
    #1;

    // Reset wins over a simultaneous valid op.
    issue(ALU_PLUS, 64'd1, 64'd1, 6'd0, 1'b1, COND_AL, 4'b1111);
    expect_out("reset", 64'd0, 4'b0000, 1'b0, 1'b0);
    in_rst = 1'b0;
    idle();
    expect_out("post_reset_idle", 64'd0, 4'b0000, 1'b0, 1'b0);

    issue(ALU_PLUS, 64'd5, 64'hFFF, 6'd0, 1'b0, COND_AL, 4'b1010);
    expect_out("plus_nocc", 64'h1004, 4'b1010, 1'b1, 1'b1);
    idle();
    expect_out("hold_idle", 64'h1004, 4'b1010, 1'b1, 1'b0);

    // Back-to-back: done stays high across consecutive ops.
    issue(ALU_MINUS, 64'd5, 64'd5, 6'd0, 1'b1, COND_AL, 4'b0000);
    expect_out("minus_zero", 64'd0, 4'b0110, 1'b1, 1'b1);
    issue(ALU_MINUS, 64'd3, 64'd5, 6'd0, 1'b1, COND_AL, 4'b0110);
    expect_out("minus_neg", 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b1, 1'b1);
    issue(ALU_PLUS, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 1'b1, COND_AL, 4'b0000);
    expect_out("plus_ovf", 64'h8000_0000_0000_0000, 4'b1001, 1'b1, 1'b1);
    issue(ALU_PLUS, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 1'b1, COND_AL, 4'b0000);
    expect_out("plus_carry", 64'd0, 4'b0110, 1'b1, 1'b1);

    issue(ALU_CSEL, 64'd7, 64'd9, 6'd0, 1'b0, COND_EQ, 4'b0100);
    expect_out("csel_true", 64'd7, 4'b0100, 1'b1, 1'b1);
    issue(ALU_CSEL, 64'd7, 64'd9, 6'd0, 1'b0, COND_EQ, 4'b0000);
    expect_out("csel_false", 64'd9, 4'b0000, 1'b0, 1'b1);
    issue(ALU_CSNEG, 64'd7, 64'd1, 6'd0, 1'b0, COND_EQ, 4'b0000);
    expect_out("csneg_false", 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000, 1'b0, 1'b1);
    issue(ALU_CSINC, 64'd7, 64'd9, 6'd0, 1'b0, COND_GT, 4'b1001);
    expect_out("csinc_gt", 64'd7, 4'b1001, 1'b1, 1'b1);
    issue(ALU_CSINV, 64'd7, 64'h0F, 6'd0, 1'b0, COND_HI, 4'b0110);
    expect_out("csinv_hi", 64'hFFFF_FFFF_FFFF_FFF0, 4'b0110, 1'b0, 1'b1);

    issue(ALU_MOVK, 64'h1111_2222_3333_4444, 64'hABCD, 6'd16, 1'b0, COND_AL, 4'b0000);
    expect_out("movk16", 64'h1111_2222_ABCD_4444, 4'b0000, 1'b1, 1'b1);
    issue(ALU_ASR, 64'h8000_0000_0000_0000, 64'd4, 6'd0, 1'b1, COND_AL, 4'b0000);
    expect_out("asr4", 64'hF800_0000_0000_0000, 4'b1000, 1'b1, 1'b1);
    issue(ALU_LSR, 64'h8000_0000_0000_0000, 64'd4, 6'd0, 1'b0, COND_AL, 4'b0000);
    expect_out("lsr4", 64'h0800_0000_0000_0000, 4'b0000, 1'b1, 1'b1);
    issue(ALU_LSL, 64'h1234, 64'h40, 6'd0, 1'b0, COND_AL, 4'b0000);
    expect_out("lsl0", 64'h1234, 4'b0000, 1'b1, 1'b1);
    issue(ALU_ORN, 64'h0, 64'hFFFF_FFFF_FFFF_FF00, 6'd0, 1'b1, COND_AL, 4'b0000);
    expect_out("orn", 64'hFF, 4'b0000, 1'b1, 1'b1);

    issue(ALU_CBZ, 64'd0, 64'd3, 6'd0, 1'b0, COND_NE, 4'b0000);
    expect_out("cbz_zero", 64'd0, 4'b0000, 1'b1, 1'b1);
    issue(ALU_CBNZ, 64'd0, 64'd3, 6'd0, 1'b0, COND_AL, 4'b0000);
    expect_out("cbnz_zero", 64'd0, 4'b0000, 1'b0, 1'b1);
    issue(alu_op_t'(5'd17), 64'd5, 64'd6, 6'd0, 1'b1, COND_AL, 4'b0011);
    expect_out("unused_op", 64'd0, 4'b0011, 1'b1, 1'b1);
    idle();
    expect_out("final_idle", 64'd0, 4'b0011, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arithmetic_execute_unit.md
Name: arithmetic_execute_unit

Overview:
Single-cycle-latency integer ALU functional unit of the Tomasulo core. It receives an operation and two 64-bit operands from the reservation stations, computes the result, NZCV flags and a condition/branch bit, and registers them for the ROB broadcast path. It also evaluates AArch64 condition codes for conditional-select and compare-branch ops.

Parameters:
GPR_SIZE, 64, operand/result width (shared constant `GPR_SIZE`).

Ports:
in_clk  input  1  clock; all state updates on the rising edge.
in_rst  input  1  synchronous reset, active-high.
in_valid  input  1  operation present this cycle.
in_alu_op  input  5 (alu_op_t)  operation select.
in_val_a  input  64  operand A.
in_val_b  input  64  operand B (register value or immediate).
in_alu_val_hw  input  6  MOVK bit position (0/16/32/48).
in_set_CC  input  1  update flags from this result.
in_cond  input  4 (cond_t)  condition code.
in_prev_nzcv  input  4 (nzcv_t)  current flags.
out_res  output  64  registered result.
out_nzcv  output  4  registered flags.
out_cond_val  output  1  registered condition / branch-taken bit.
out_fu_done  output  1  one-cycle pulse: outputs valid.

Behaviour:
- Reset (in_rst=1 at clock edge): out_res=0, out_nzcv=0, out_cond_val=0, out_fu_done=0. Reset beats a simultaneous in_valid; that op is dropped.
- Latency: op sampled when in_valid=1 at edge N; results and out_fu_done=1 visible after edge N. out_fu_done=0 on every cycle with no valid op. Outputs hold their last value while idle. Back-to-back ops each cycle are accepted, no stall.
- alu_op_t encodings:
  - 0 PLUS a+b
  - 1 MINUS a+~b+1
  - 2 ORN a|~b
  - 3 OR
  - 4 EOR
  - 5 AND
  - 6 MOVK (a & ~(0xFFFF<<hw)) | (b[15:0]<<hw)
  - 7 LSL a<<b[5:0]
  - 8 LSR logical a>>b[5:0]
  - 9 ASR arithmetic a>>>b[5:0]
  - 10 PASS_A a
  - 11 CSEL c?a:b
  - 12 CSINV c?a:~b
  - 13 CSINC c?a:b+1
  - 14 CSNEG c?a:-b
  - 15 CBZ res=a
  - 16 CBNZ res=a
  - Unused codes: res=0, no flag change.
- Flags when in_set_CC=1:
  - N=res[63], Z=(res==0).
  - PLUS: C=carry-out of bit 63; V=signed overflow (operands same sign, result differs).
  - MINUS: C=carry-out of a+~b+1 (1 = no borrow); V=signed overflow of a-b.
  - All other ops: C=0, V=0.
- When in_set_CC=0, out_nzcv=in_prev_nzcv unchanged.
- Condition c is evaluated on in_prev_nzcv, never on the flags being computed this cycle. ARM encoding:
  - EQ0 Z; NE1 !Z; CS2 C; CC3 !C; MI4 N; PL5 !N; VS6 V; VC7 !V
  - HI8 C&!Z; LS9 !(C&!Z); GE10 N==V; LT11 N!=V
  - GT12 !Z&(N==V); LE13 !(GT); AL14 1; NV15 1
- out_cond_val: CBZ → (a==0); CBNZ → (a!=0); all other ops → c.
- All arithmetic is modulo 2^64; shifts by 0 return a.

Decomposition:
- Shared package (data_structures): `GPR_SIZE`, alu_op_t (5-bit enum), cond_t (4-bit enum), nzcv_t (packed struct {N,Z,C,V}, N at MSB).
- One natural sub-module: cond_eval (combinational cond_t + nzcv_t → 1 bit).
- Datapath and flag logic: combinational block feeding one output register stage.

Test Plan:
- Reset: in_rst=1 with in_valid=1, PLUS 1+1 → next cycle all outputs 0, out_fu_done=0.
- PLUS a=5, b=0xFFF, set_CC=0, prev_nzcv=4'b1010 → out_res=0x1004, out_nzcv=4'b1010, out_fu_done=1 for exactly one cycle.
- MINUS a=5, b=5, set_CC=1 → out_res=0, out_nzcv=4'b0110; then MINUS 3-5 → res=0xFFFF_FFFF_FFFF_FFFE, nzcv=4'b1000.
- PLUS a=0x7FFF_FFFF_FFFF_FFFF, b=1, set_CC=1 → res=0x8000_0000_0000_0000, nzcv=4'b1001.
- CSEL cond=EQ, prev_nzcv=4'b0100, a=7, b=9 → res=7, cond_val=1; same with prev_nzcv=0 → res=9, cond_val=0. CSNEG false, b=1 → res=all-ones.
- MOVK a=0x1111_2222_3333_4444, b=0xABCD, hw=16 → res=0x1111_2222_ABCD_4444. CBZ a=0 → cond_val=1. Back-to-back ops → done stays high two cycles with correct results each.
